decoder_strobe: RTL and testbench
=================================

// Module: decoder_strobe
// PURPOSE
//  Binary-to-one-hot decoder with timed strobes: inverse of the 16-to-4 encoder.
//  Accepts a code over a valid/ready handshake and drives exactly one bit of
//  decoder_out for PULSE_LEN cycles, then all-zero for GAP_LEN cycles.
//  Holds one further code in a single-entry buffer, so strobe trains are back-to-back.
//  Sits between control logic issuing select codes and the 16 per-line strobes.
// PARAMETERS
//  WIDTH      4  code width; decoder_out width N = 2**WIDTH
//  PULSE_LEN  4  cycles each one-hot strobe is held; must be >= 1
//  GAP_LEN    1  all-zero cycles between strobes; 0 = no gap
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  enable       in   1      block enable; low aborts and flushes
//  in_valid     in   1      binary_in valid
//  in_ready     out  1      block can take a code this cycle
//  binary_in    in   WIDTH  code to decode
//  decoder_out  out  N      registered one-hot strobe, or all-zero
//  busy         out  1      state != IDLE or buffer occupied
//  done         out  1      1-cycle pulse on last DRIVE cycle of each strobe
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, counter=0, buffer empty.
//    Outputs decoder_out=0, in_ready=0, busy=0, done=0, all immediately without clk.
//  - in_ready = enable & ~buf_valid (combinational). Transfer = in_valid & in_ready.
//  - Decode: code k -> decoder_out = 1<<k. Code 0 -> 'h0001, code 15 -> 'h8000 (N=16).
//  - FSM states IDLE, DRIVE, GAP.
//    IDLE:  transfer at edge t -> DRIVE; decoder_out = 1<<k from cycle t+1.
//           Bypass path: the code goes straight to the output register, not via the buffer.
//    DRIVE: counter loads PULSE_LEN-1 and decrements each cycle; done=1 when counter==0.
//           At counter==0, exit to GAP (GAP_LEN>0) with counter=GAP_LEN-1 and decoder_out=0.
//    GAP:   counts down to 0, decoder_out=0.
//  - Next-code selection, made on the last cycle of DRIVE (GAP_LEN=0) or last cycle of GAP.
//    Priority: buffered code, then a transfer in that same cycle, else IDLE.
//    A selected code enters DRIVE directly. A transfer in DRIVE/GAP that is not consumed
//    by the selection goes into the buffer.
//  - Buffer: one entry. in_ready=0 while full. Frees on the cycle it is loaded into DRIVE.
//  - enable=0: in_ready=0 at once. At the next edge: state=IDLE, decoder_out=0,
//    buffer flushed, counter=0, no done. Codes are never replayed after re-enable.
//  - in_valid while enable=0: ignored, no transfer.
//  - Counter width = $clog2(max(PULSE_LEN,GAP_LEN)+1). No wrap; it reloads at each state entry.
//  - decoder_out is never multi-hot: at most one bit set in any cycle.
//  - busy=1 from the cycle after any transfer until IDLE with buffer empty.
// STRUCTURE
//  - decoder_pkg: state enum typedef (IDLE/DRIVE/GAP), function onehot(code, N),
//    localparam for counter width.
//  - Sub-module strobe_buf: single-entry valid/data holding register with flush input.
//    FSM, counter and output register are in decoder_strobe.
// TESTING (WIDTH=4, PULSE_LEN=3, GAP_LEN=1 unless stated; cycle 0 = transfer edge)
//  1. Assert rst_n=0 mid-sim, with enable=1 and in_valid=1.
//     -> all outputs 0 asynchronously. After rst_n=1: in_ready=1, decoder_out=0.
//  2. binary_in=5 single transfer.
//     -> decoder_out='h0020 cycles 1-3; done=1 cycle 3; decoder_out=0 cycle 4;
//        busy=0 from cycle 5.
//  3. Code 0 at cycle 0, code 15 at cycle 1.
//     -> 'h0001 cycles 1-3, 0 cycle 4, 'h8000 cycles 5-7.
//        in_ready=0 cycles 2-4; buffer frees at cycle 5.
//  4. Code 9 then enable=0 at cycle 2, with code 3 buffered.
//     -> decoder_out=0 from cycle 3, busy=0, no done.
//        After re-enable, code 3 is never output.
//  5. rst_n pulsed low during DRIVE of code 7 (no clk edge).
//     -> decoder_out 'h0080 -> 0 immediately; FSM IDLE after release.
//  6. GAP_LEN=0, codes 1,2,3 streamed with in_valid held high.
//     -> 'h0002,'h0004,'h0008, each 3 cycles, contiguous, no zero cycle; done every 3rd cycle.
//  7. All 16 codes, random in_valid gaps.
//     -> each output equals 1<<code, in order, never multi-hot (assertion).

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the timed one-hot strobe decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_PULSE_LEN = 4;
  localparam int unsigned DEF_GAP_LEN   = 1;

  // Bit idx of the one-hot vector selected by code.
  function automatic logic onehot(input int unsigned code, input int unsigned idx);
    return code == idx;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned pulse_len,
                                            input int unsigned gap_len);
    return $clog2(((pulse_len > gap_len) ? pulse_len : gap_len) + 1);
  endfunction

endpackage

// File: rtl/strobe_buf.sv
// Single-entry holding register for the code queued behind the active strobe.
module strobe_buf
  import decoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_code,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] code
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the data word is qualified by valid, so it needs no reset and stays a plain enable flop.
  always_ff @(posedge clk) begin
    if (push) begin
      code <= push_code;
    end
  end

endmodule

// File: rtl/decoder_strobe.sv
// Binary-to-one-hot decoder driving timed strobes with a one-code lookahead buffer.
module decoder_strobe
  import decoder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
  parameter int unsigned GAP_LEN   = DEF_GAP_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary_in,
  output logic [(2**WIDTH)-1:0] decoder_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N     = 2 ** WIDTH;
  localparam int unsigned CNT_W = cnt_width(PULSE_LEN, GAP_LEN);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [N-1:0]       out_q, out_d;
  logic               transfer, pick, load;
  logic [WIDTH-1:0]   load_code;
  logic               buf_valid, buf_push, buf_pop;
  logic [WIDTH-1:0]   buf_code;

  // Gated by rst_n so the handshake is closed for the whole reset window.
  assign in_ready = rst_n & enable & ~buf_valid;
  assign transfer = in_valid & in_ready;

  strobe_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (~enable),
    .push      (buf_push),
    .push_code (binary_in),
    .pop       (buf_pop),
    .valid     (buf_valid),
    .code      (buf_code)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    out_d     = out_q;
    pick      = 1'b0;
    load      = 1'b0;
    load_code = binary_in;
    buf_pop   = 1'b0;

    unique case (state)
      IDLE: load = transfer;
      DRIVE: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (GAP_LEN > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
          out_d   = '0;
        end else begin
          pick = 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) cnt_d = cnt - CNT_W'(1);
        else           pick  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // End of a strobe train: the buffered code outranks a same-cycle transfer.
    if (pick) begin
      if (buf_valid) begin
        load      = 1'b1;
        load_code = buf_code;
        buf_pop   = 1'b1;
      end else if (transfer) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = '0;
      end
    end

    buf_push = transfer && (state != IDLE) && !pick;

    if (load) begin
      state_d = DRIVE;
      cnt_d   = PULSE_LD;
      for (int unsigned i = 0; i < N; i++) begin
        out_d[i] = onehot(32'(load_code), i);
      end
    end

    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      out_d    = '0;
      buf_push = 1'b0;
      buf_pop  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      out_q <= out_d;
    end
  end

  assign decoder_out = out_q;
  assign busy        = (state != IDLE) | buf_valid;
  assign done        = enable & (state == DRIVE) & (cnt == '0);

endmodule

// File: tb/tb_decoder_strobe.sv
// Directed bench for decoder_strobe: PULSE_LEN=3 with GAP_LEN=1 and GAP_LEN=0 instances.
module tb_decoder_strobe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_enable, a_valid, a_ready, a_busy, a_done;
  logic [3:0]  a_code;
  logic [15:0] a_out;
  logic        b_enable, b_valid, b_ready, b_busy, b_done;
  logic [3:0]  b_code;
  logic [15:0] b_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_strobe #(.WIDTH(4), .PULSE_LEN(3), .GAP_LEN(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .in_valid(a_valid), .in_ready(a_ready),
    .binary_in(a_code), .decoder_out(a_out), .busy(a_busy), .done(a_done)
  );

  decoder_strobe #(.WIDTH(4), .PULSE_LEN(3), .GAP_LEN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .in_valid(b_valid), .in_ready(b_ready),
    .binary_in(b_code), .decoder_out(b_out), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: cross the rising edge, then land on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // The output must never carry more than one set bit.
  always @(negedge clk) begin
    check("a_onehot0", 32'($onehot0(a_out)), 32'd1);
    check("b_onehot0", 32'($onehot0(b_out)), 32'd1);
  end

  initial begin
    rst_n = 1'b0;
    a_enable = 1'b0; a_valid = 1'b0; a_code = '0;
    b_enable = 1'b0; b_valid = 1'b0; b_code = '0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(a_out), 32'h0);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    rst_n = 1'b1; a_enable = 1'b1; b_enable = 1'b1;
    #1;
    check("post_rst_ready", 32'(a_ready), 32'd1);
    @(negedge clk);

    // Single transfer of code 5.
    a_valid = 1'b1; a_code = 4'd5;
    tick(); a_valid = 1'b0;
    check("t2_c1_out", 32'(a_out), 32'h0020);
    check("t2_c1_busy", 32'(a_busy), 32'd1);
    check("t2_c1_done", 32'(a_done), 32'd0);
    tick();
    check("t2_c2_out", 32'(a_out), 32'h0020);
    tick();
    check("t2_c3_out", 32'(a_out), 32'h0020);
    check("t2_c3_done", 32'(a_done), 32'd1);
    tick();
    check("t2_c4_out", 32'(a_out), 32'h0);
    check("t2_c4_done", 32'(a_done), 32'd0);
    check("t2_c4_busy", 32'(a_busy), 32'd1);
    tick();
    check("t2_c5_busy", 32'(a_busy), 32'd0);
    check("t2_c5_out", 32'(a_out), 32'h0);

    // Code 0 then code 15 queued behind it.
    a_valid = 1'b1; a_code = 4'd0;
    tick();
    check("t3_c1_out", 32'(a_out), 32'h0001);
    check("t3_c1_ready", 32'(a_ready), 32'd1);
    a_code = 4'd15;
    tick(); a_valid = 1'b0;
    check("t3_c2_out", 32'(a_out), 32'h0001);
    check("t3_c2_ready", 32'(a_ready), 32'd0);
    tick();
    check("t3_c3_done", 32'(a_done), 32'd1);
    check("t3_c3_ready", 32'(a_ready), 32'd0);
    tick();
    check("t3_c4_out", 32'(a_out), 32'h0);
    check("t3_c4_ready", 32'(a_ready), 32'd0);
    tick();
    check("t3_c5_out", 32'(a_out), 32'h8000);
    check("t3_c5_ready", 32'(a_ready), 32'd1);
    tick();
    check("t3_c6_out", 32'(a_out), 32'h8000);
    tick();
    check("t3_c7_out", 32'(a_out), 32'h8000);
    check("t3_c7_done", 32'(a_done), 32'd1);
    tick();
    check("t3_c8_out", 32'(a_out), 32'h0);
    tick();
    check("t3_c9_busy", 32'(a_busy), 32'd0);

    // Asynchronous reset mid-strobe with enable and in_valid high.
    a_valid = 1'b1; a_code = 4'd4;
    tick();
    check("t1_pre_out", 32'(a_out), 32'h0010);
    a_code = 4'd6;
    #1 rst_n = 1'b0;
    #1;
    check("t1_rst_out", 32'(a_out), 32'h0);
    check("t1_rst_ready", 32'(a_ready), 32'd0);
    check("t1_rst_busy", 32'(a_busy), 32'd0);
    check("t1_rst_done", 32'(a_done), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("t1_rel_ready", 32'(a_ready), 32'd1);
    check("t1_rel_out", 32'(a_out), 32'h0);
    a_valid = 1'b0;
    @(negedge clk);
    tick();
    check("t1_idle_busy", 32'(a_busy), 32'd0);

    // Disable while code 9 drives and code 3 is buffered.
    a_valid = 1'b1; a_code = 4'd9;
    tick();
    check("t4_c1_out", 32'(a_out), 32'h0200);
    a_code = 4'd3;
    tick(); a_valid = 1'b0;
    check("t4_c2_out", 32'(a_out), 32'h0200);
    check("t4_c2_busy", 32'(a_busy), 32'd1);
    a_enable = 1'b0;
    tick();
    check("t4_c3_out", 32'(a_out), 32'h0);
    check("t4_c3_busy", 32'(a_busy), 32'd0);
    check("t4_c3_done", 32'(a_done), 32'd0);
    check("t4_c3_ready", 32'(a_ready), 32'd0);
    a_enable = 1'b1;
    #1;
    check("t4_reen_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t4_no_replay", 32'(a_out), 32'h0);
    end
    a_enable = 1'b0; a_valid = 1'b1; a_code = 4'd2;
    tick();
    check("t4_dis_ignore_out", 32'(a_out), 32'h0);
    check("t4_dis_ignore_busy", 32'(a_busy), 32'd0);
    a_valid = 1'b0; a_enable = 1'b1;
    tick();
    check("t4_dis_ignore_out2", 32'(a_out), 32'h0);

    // Reset pulse during the drive of code 7, no clock edge while low.
    a_valid = 1'b1; a_code = 4'd7;
    tick(); a_valid = 1'b0;
    check("t5_c1_out", 32'(a_out), 32'h0080);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_out", 32'(a_out), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tick();
    check("t5_idle_busy", 32'(a_busy), 32'd0);
    check("t5_idle_out", 32'(a_out), 32'h0);
    check("t5_idle_ready", 32'(a_ready), 32'd1);

    // Back-to-back stream on the no-gap instance.
    for (int c = 0; c <= 10; c++) begin
      b_valid = (c <= 4);
      b_code  = (c == 0) ? 4'd1 : (c == 1) ? 4'd2 : 4'd3;
      if (c >= 1) begin
        check("t6_out", 32'(b_out), (c <= 9) ? (32'd1 << ((c - 1) / 3 + 1)) : 32'h0);
        check("t6_done", 32'(b_done), 32'((c % 3 == 0) && (c <= 9)));
      end
      if (c >= 2 && c <= 4) check("t6_ready", 32'(b_ready), 32'(c == 4));
      tick();
    end
    check("t6_busy_end", 32'(b_busy), 32'd0);

    // All sixteen codes in order with random idle gaps.
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          int guard;
          a_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
          a_valid = 1'b1; a_code = 4'(k);
          guard = 0;
          while (!a_ready && guard < 50) begin
            tick();
            guard++;
          end
          check("t7_ready_wait", 32'(guard < 50), 32'd1);
          tick();
        end
        a_valid = 1'b0;
      end
      begin
        int seen = 0;
        logic [15:0] prev = '0;
        for (int cyc = 0; cyc < 2000 && seen < 16; cyc++) begin
          @(negedge clk);
          if (a_out != 16'h0 && prev == 16'h0) begin
            check("t7_code", 32'(a_out), 32'd1 << seen);
            seen++;
          end
          prev = a_out;
        end
        check("t7_all_seen", 32'(seen), 32'd16);
      end
    join
    repeat (6) tick();
    check("t7_idle", 32'(a_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
